// File: rtl/arm_pipeline_pkg.sv
// arm_pipeline_pkg: shared widths, encodings and pipeline-register types for the ARMv8 pipeline
package arm_pipeline_pkg;
  localparam int PC_WIDTH = 64;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hD503201F;
  localparam logic [5:0] OPC_B = 6'b000101;
  localparam logic [5:0] OPC_BL = 6'b100101;
  localparam logic [4:0] LINK_REG = 5'd30;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0] pc;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/early_branch_decoder.sv
// early_branch_decoder: combinational B/BL detect, target and link-address computation
module early_branch_decoder
  import arm_pipeline_pkg::OPC_B, arm_pipeline_pkg::OPC_BL;
#(
  parameter int PC_WIDTH = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   valid,
  output logic                   is_b,
  output logic                   is_bl,
  output logic [PC_WIDTH-1:0]    target,
  output logic [PC_WIDTH-1:0]    link_data
);
  assign is_b = valid && instr[31:26] == OPC_B;
  assign is_bl = valid && instr[31:26] == OPC_BL;
  assign target = pc + {{(PC_WIDTH-28){instr[25]}}, instr[25:0], 2'b00};
  assign link_data = pc + PC_WIDTH'(4);
endmodule

// File: rtl/fetch_redirect_stage.sv
// fetch_redirect_stage: PC register, IF/ID register and early B/BL redirect with EX override
module fetch_redirect_stage #(
  parameter int PC_WIDTH = arm_pipeline_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = arm_pipeline_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = arm_pipeline_pkg::NOP_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   ex_redirect,
  input  logic [PC_WIDTH-1:0]    ex_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    PC_out,
  output logic [INSTR_WIDTH-1:0] instruction_IF_ID,
  output logic [PC_WIDTH-1:0]    pc_IF_ID,
  output logic                   valid_IF_ID,
  output logic                   id_branch_taken,
  output logic                   link_we,
  output logic [PC_WIDTH-1:0]    link_data
);
  logic [PC_WIDTH-1:0] pc, target;
  logic is_b, is_bl;
  early_branch_decoder #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) decoder (
    .instr(instruction_IF_ID),
    .pc(pc_IF_ID),
    .valid(valid_IF_ID),
    .is_b(is_b),
    .is_bl(is_bl),
    .target(target),
    .link_data(link_data)
  );
  // an EX redirect outranks a held or firing ID branch, so neither may report a redirect
  assign id_branch_taken = (is_b || is_bl) && !stall && !ex_redirect;
  assign link_we = id_branch_taken && is_bl;
  assign imem_addr = pc;
  assign PC_out = pc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      instruction_IF_ID <= NOP_INSTR;
      pc_IF_ID <= '0;
      valid_IF_ID <= 1'b0;
    end else if (ex_redirect) begin
      pc <= ex_target;
      instruction_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end else if (!stall) begin
      pc <= id_branch_taken ? target : pc + PC_WIDTH'(4);
      instruction_IF_ID <= id_branch_taken ? NOP_INSTR : imem_rdata;
      pc_IF_ID <= pc;
      valid_IF_ID <= !id_branch_taken;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_stage.sv
// tb_fetch_redirect_stage: directed vector table plus randomized run against a spec-level model
module tb_fetch_redirect_stage;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic clock = 1'b1, reset = 1'b1, stall = 1'b0, ex_redirect = 1'b0;
  logic [63:0] ex_target = '0;
  logic [63:0] imem_addr, PC_out, pc_IF_ID, link_data;
  logic [31:0] imem_rdata, instruction_IF_ID;
  logic valid_IF_ID, id_branch_taken, link_we;
  logic [31:0] mem [256];
  logic [63:0] x30 = '0;
  int checks = 0, errors = 0;

  fetch_redirect_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC_out(PC_out), .instruction_IF_ID(instruction_IF_ID), .pc_IF_ID(pc_IF_ID),
    .valid_IF_ID(valid_IF_ID), .id_branch_taken(id_branch_taken),
    .link_we(link_we), .link_data(link_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] fetch(input logic [63:0] a);
    return a < 64'd1024 ? mem[a[9:2]] : NOP;
  endfunction

  assign imem_rdata = fetch(imem_addr);

  always @(posedge clock) if (link_we) x30 <= link_data;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  typedef struct {
    logic st, exr;
    logic [63:0] ext, pc;
    logic v;
    logic [31:0] ins;
    logic [63:0] pcq;
    logic t, lw;
  } vec_t;
  vec_t tbl [19];

  task automatic chk_state(input string tag, input logic [63:0] pc, input logic v,
                           input logic [31:0] ins, input logic [63:0] pcq,
                           input logic t, input logic lw);
    chk({tag, " pc"}, PC_out, pc);
    chk({tag, " imem_addr"}, imem_addr, pc);
    chk({tag, " valid"}, 64'(valid_IF_ID), 64'(v));
    chk({tag, " taken"}, 64'(id_branch_taken), 64'(t));
    chk({tag, " link_we"}, 64'(link_we), 64'(lw));
    if (v) begin
      chk({tag, " instr"}, 64'(instruction_IF_ID), 64'(ins));
      chk({tag, " pc_if_id"}, pc_IF_ID, pcq);
      chk({tag, " link_data"}, link_data, pcq + 64'd4);
    end
  endtask

  logic [63:0] m_pc, m_pcq, tgt;
  logic [31:0] m_ins;
  logic m_v, fire, bl;
  logic [5:0] op;
  logic signed [63:0] off;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0] = 32'h8B020020;
    mem[1] = 32'h14000006;
    mem[7] = 32'h94000002;
    mem[9] = 32'h14000007;
    mem[16] = 32'h17FFFFFE;
    mem[14] = 32'h14000000;
    mem[65] = 32'h94000010;
    tbl[0]  = '{0, 0, 0, 64'h4,   1, 32'h8B020020, 64'h0,   0, 0};
    tbl[1]  = '{0, 0, 0, 64'h8,   1, 32'h14000006, 64'h4,   1, 0};
    tbl[2]  = '{0, 0, 0, 64'h1C,  0, NOP,          64'h0,   0, 0};
    tbl[3]  = '{0, 0, 0, 64'h20,  1, 32'h94000002, 64'h1C,  1, 1};
    tbl[4]  = '{0, 0, 0, 64'h24,  0, NOP,          64'h0,   0, 0};
    tbl[5]  = '{0, 0, 0, 64'h28,  1, 32'h14000007, 64'h24,  1, 0};
    tbl[6]  = '{0, 0, 0, 64'h40,  0, NOP,          64'h0,   0, 0};
    tbl[7]  = '{0, 0, 0, 64'h44,  1, 32'h17FFFFFE, 64'h40,  1, 0};
    tbl[8]  = '{0, 0, 0, 64'h38,  0, NOP,          64'h0,   0, 0};
    tbl[9]  = '{0, 0, 0, 64'h3C,  1, 32'h14000000, 64'h38,  1, 0};
    tbl[10] = '{0, 0, 0, 64'h38,  0, NOP,          64'h0,   0, 0};
    tbl[11] = '{1, 1, 64'h100, 64'h3C, 1, 32'h14000000, 64'h38, 0, 0};
    tbl[12] = '{0, 0, 0, 64'h100, 0, NOP,          64'h0,   0, 0};
    tbl[13] = '{0, 0, 0, 64'h104, 1, NOP,          64'h100, 0, 0};
    tbl[14] = '{1, 0, 0, 64'h108, 1, 32'h94000010, 64'h104, 0, 0};
    tbl[15] = '{1, 0, 0, 64'h108, 1, 32'h94000010, 64'h104, 0, 0};
    tbl[16] = '{1, 0, 0, 64'h108, 1, 32'h94000010, 64'h104, 0, 0};
    tbl[17] = '{0, 0, 0, 64'h108, 1, 32'h94000010, 64'h104, 1, 1};
    tbl[18] = '{0, 0, 0, 64'h144, 0, NOP,          64'h0,   0, 0};
    #12;
    chk_state("reset", 64'h0, 1'b0, NOP, 64'h0, 1'b0, 1'b0);
    chk("reset instr", 64'(instruction_IF_ID), 64'(NOP));
    #3 reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 19; i++) begin
      stall = tbl[i].st;
      ex_redirect = tbl[i].exr;
      ex_target = tbl[i].ext;
      #1;
      chk_state($sformatf("row%0d", i), tbl[i].pc, tbl[i].v, tbl[i].ins, tbl[i].pcq, tbl[i].t, tbl[i].lw);
      if (i == 4) chk("x30 after BL", x30, 64'h20);
      @(posedge clock); #1;
      stall = 1'b0; ex_redirect = 1'b0;
    end
    chk("x30 after stalled BL", x30, 64'h108);
    ex_redirect = 1'b1; ex_target = 64'h200;
    #3 reset = 1'b1;
    #1;
    chk_state("async reset", 64'h0, 1'b0, NOP, 64'h0, 1'b0, 1'b0);
    chk("async reset instr", 64'(instruction_IF_ID), 64'(NOP));
    chk("async reset pcq", pc_IF_ID, 64'h0);
    #2 reset = 1'b0; ex_redirect = 1'b0;
    @(posedge clock); #1;
    chk_state("post reset", 64'h4, 1'b1, 32'h8B020020, 64'h0, 1'b0, 1'b0);
    ex_redirect = 1'b1; ex_target = 64'hFFFF_FFFF_FFFF_FFF8;
    @(posedge clock); #1;
    ex_redirect = 1'b0;
    chk_state("wrap a", 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, NOP, 64'h0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk_state("wrap b", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, NOP, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk_state("wrap c", 64'h0, 1'b1, NOP, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 3))
        0: mem[i] = {6'b000101, 26'($signed($urandom_range(0, 20)) - 10)};
        1: mem[i] = {6'b100101, 26'($signed($urandom_range(0, 20)) - 10)};
        default: begin
          mem[i] = $urandom;
          if (mem[i][31:26] == 6'b000101 || mem[i][31:26] == 6'b100101) mem[i] = NOP;
        end
      endcase
    end
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    m_pc = '0; m_pcq = '0; m_ins = NOP; m_v = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 2000; c++) begin
      m_ins = m_v ? m_ins : m_ins;
      if (c == 0) begin
        m_pc = 64'h4; m_ins = mem[0]; m_pcq = 64'h0; m_v = 1'b1;
      end
      stall = $urandom_range(0, 3) == 0;
      ex_redirect = $urandom_range(0, 9) == 0;
      ex_target = 64'($urandom_range(0, 280)) * 4;
      #1;
      op = m_ins[31:26];
      fire = m_v && (op == 6'b000101 || op == 6'b100101) && !stall && !ex_redirect;
      bl = fire && op == 6'b100101;
      off = 64'($signed(m_ins[25:0]));
      tgt = m_pcq + 64'(off * 4);
      chk_state($sformatf("rand%0d", c), m_pc, m_v, m_ins, m_pcq, fire, bl);
      if (ex_redirect) begin
        m_pc = ex_target; m_ins = NOP; m_v = 1'b0;
      end else if (!stall) begin
        if (fire) begin
          m_pc = tgt; m_ins = NOP; m_v = 1'b0;
        end else begin
          m_ins = fetch(m_pc); m_pcq = m_pc; m_v = 1'b1; m_pc = m_pc + 64'd4;
        end
      end
      @(posedge clock); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_stage.md
Name: fetch_redirect_stage

Overview:
Fetch stage of the pipelined ARMv8 core. It owns the PC register, drives the instruction-memory address and holds the IF/ID pipeline register. It resolves unconditional B/BL early, in ID, with a one-bubble penalty. It also accepts late redirects from EX (conditional branches) and stalls from the hazard unit.

Parameters:
PC_WIDTH, 64, width of PC and all address/target ports
INSTR_WIDTH, 32, instruction word width
RESET_PC, 64'h0, PC value loaded by reset
NOP_INSTR, 32'hD503201F, bubble word written into IF/ID on flush

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID (hazard unit)
ex_redirect  in  1  EX resolved a taken branch
ex_target  in  PC_WIDTH  EX branch target
imem_addr  out  PC_WIDTH  instruction-memory address (= PC_out)
imem_rdata  in  INSTR_WIDTH  combinational instruction-memory read data
PC_out  out  PC_WIDTH  current fetch PC
instruction_IF_ID  out  INSTR_WIDTH  IF/ID instruction
pc_IF_ID  out  PC_WIDTH  IF/ID PC
valid_IF_ID  out  1  IF/ID holds a real instruction (0 = bubble)
id_branch_taken  out  1  early B/BL redirect fires this cycle
link_we  out  1  write X30 this cycle (BL)
link_data  out  PC_WIDTH  pc_IF_ID + 4

Behaviour:
- Reset (asynchronous, any time, including mid-branch):
  - PC <= RESET_PC, instruction_IF_ID <= NOP_INSTR, pc_IF_ID <= 0, valid_IF_ID <= 0.
  - Combinational outputs follow these values: id_branch_taken=0, link_we=0.
- imem_addr = PC_out = PC, combinational. The fetched word is registered into IF/ID at the next edge, so IF/ID latency is 1 cycle.
- Early decode applies to the IF/ID word, gated by valid_IF_ID:
  - B: opcode [31:26] = 6'b000101.
  - BL: opcode [31:26] = 6'b100101.
  - target = pc_IF_ID + (sign_extend(imm26 = [25:0]) << 2), computed modulo 2^PC_WIDTH.
- Next-state priority, evaluated per edge, highest first:
  1. ex_redirect=1: PC <= ex_target; IF/ID <= NOP, valid=0. This overrides stall and any ID branch.
  2. stall=1: PC and IF/ID hold. id_branch_taken=0 and link_we=0 while stalled; the B/BL fires once stall drops.
  3. ID B/BL valid: id_branch_taken=1; PC <= target; IF/ID <= NOP, valid=0, squashing the wrong-path fetch.
  4. Otherwise: PC <= PC+4; IF/ID <= {imem_rdata, PC}, valid=1.
- link_we = id_branch_taken AND the ID word is BL. link_data = pc_IF_ID + 4, always driven. The register file performs the write at the same edge.
- Penalties: exactly 1 bubble per taken B/BL; exactly 1 bubble per EX redirect as seen by IF/ID (older-stage flush is the EX owner's concern).
- A B/BL that arrives in ID immediately after a flush is not possible, because the bubble has valid=0 and so never triggers.
- Self-loop (B #0) redirects to its own PC every other cycle without hanging.
- PC wrap past 2^64-4 wraps silently.
- Pipeline registers and combinational decode are cleanly separated; no latches.

Decomposition:
- Shared package arm_pipeline_pkg:
  - PC_WIDTH, INSTR_WIDTH, NOP_INSTR.
  - OPC_B = 6'b000101, OPC_BL = 6'b100101.
  - LINK_REG = 5'd30.
  - typedef if_id_t {instr, pc, valid}.
- One combinational sub-module, early_branch_decoder.
  - Inputs: instr, pc, valid.
  - Outputs: is_b, is_bl, target, link_data.
  - Reused later by a branch-predictor stage.

Test Plan:
- Reset: hold reset for 15 ns, then release -> PC_out=0, valid_IF_ID=0 during reset; PC_out=4 one edge after release, IF/ID={mem[0],0,valid=1}.
- B: word 0x14000006 (B #24) at 0x4 -> when pc_IF_ID=0x4: id_branch_taken=1; next PC_out=0x1C; IF/ID=NOP with valid=0 (0x8 squashed); 0x1C fetched next.
- BL: 0x94000002 (BL #8) at 0x1C -> link_we=1, link_data=0x20, X30=0x20 after the edge, next PC_out=0x24.
- Backward branch: 0x17FFFFFE (B #-8) at 0x40 -> next PC=0x38. Chained B #0 at 0x38 alternates PC_out 0x38 / 0x3C / 0x38 with no hang.
- Priority: ex_redirect=1 (ex_target=0x100) in the same cycle as a valid B in ID and stall=1 -> PC=0x100, link_we=0, IF/ID=NOP.
- Stall and reset mid-operation:
  - Stall for 3 cycles with BL in ID -> PC and IF/ID frozen, link_we=0; on release -> link_we=1 for exactly 1 cycle.
  - Reset asserted between edges during a redirect -> outputs return to reset values immediately (asynchronous).
